// File: rtl/serial_sub_unit.sv
// serial_sub_unit
// Bit-serial unsigned subtractor: diff = a - b, processed LSB first through a
// single full-subtractor cell and a borrow flip-flop. A start/busy/done
// handshake frames each operation; all outputs come straight from flops.

module serial_sub_unit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  // Counter is sized to hold WIDTH itself, so it never wraps inside an op.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] minuend_q;
  logic [WIDTH-1:0] subtrahend_q;
  logic [WIDTH-1:0] result_q;
  logic             borrow_q;
  logic [CW-1:0]    bitCount_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;

  logic             diffBit_d;
  logic             borrow_d;
  logic [WIDTH-1:0] result_d;

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

  // One full-subtractor cell on the current LSBs, and the partial result with
  // the new bit shifted in at the MSB (the concatenation keeps WIDTH=1 legal).
  always_comb begin
    diffBit_d = minuend_q[0] ^ subtrahend_q[0] ^ borrow_q;
    borrow_d  = (~minuend_q[0] & subtrahend_q[0])
              | (~(minuend_q[0] ^ subtrahend_q[0]) & borrow_q);
    result_d  = WIDTH'({diffBit_d, result_q} >> 1);
  end

  // Control FSM and datapath: capture in IDLE, one bit per edge in SHIFT,
  // publish diff/bout on the final bit, one-cycle done pulse, then back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      minuend_q    <= '0;
      subtrahend_q <= '0;
      result_q     <= '0;
      borrow_q     <= 1'b0;
      bitCount_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      diff_q       <= '0;
      bout_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            minuend_q    <= a;
            subtrahend_q <= b;
            result_q     <= '0;
            borrow_q     <= 1'b0;
            bitCount_q   <= '0;
            busy_q       <= 1'b1;
            state_q      <= ST_SHIFT;
          end else begin
            busy_q <= 1'b0;
          end
        end

        ST_SHIFT: begin
          minuend_q    <= minuend_q >> 1;
          subtrahend_q <= subtrahend_q >> 1;
          borrow_q     <= borrow_d;
          result_q     <= result_d;
          bitCount_q   <= bitCount_q + CW'(1);
          if (bitCount_q == LAST_BIT) begin
            diff_q  <= result_d;
            bout_q  <= borrow_d;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end

        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_unit.sv
// tb_serial_sub_unit
// Directed bench for the 4-bit serial subtractor: reset values, several
// operand pairs, ignored start while busy, back-to-back accepts with start
// held high, and an asynchronous reset in the middle of an operation.

module tb_serial_sub_unit;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [3:0] a     = 4'h0;
  logic [3:0] b     = 4'h0;
  logic       busy;
  logic       done;
  logic [3:0] diff;
  logic       bout;

  int checkCount = 0;
  int passCount  = 0;
  int donePulses;

  serial_sub_unit #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Present a request for one cycle; returns #1 after the accepting edge E0.
  // Operands are scrambled afterwards to show they were captured.
  task automatic applyStimulus(input logic [3:0] opA, input logic [3:0] opB);
    @(negedge clk);
    start = 1'b1;
    a     = opA;
    b     = opB;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = ~opA;
    b     = ~opB;
  endtask

  // Full operation with edge-by-edge checks of the handshake and the result.
  task automatic runOp(input string tag, input logic [3:0] opA,
                       input logic [3:0] opB, input logic [3:0] expDiff,
                       input logic expBout);
    applyStimulus(opA, opB);
    checkOutput($sformatf("%s busy@E0", tag), busy, 1);
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("%s done@E%0d", tag, e), done, (e == 4) ? 1 : 0);
    end
    checkOutput($sformatf("%s diff", tag), diff, expDiff);
    checkOutput($sformatf("%s bout", tag), bout, expBout);
    checkOutput($sformatf("%s busy@E4", tag), busy, 1);
    @(posedge clk);
    #1;
    checkOutput($sformatf("%s done@E5", tag), done, 0);
    checkOutput($sformatf("%s busy@E5", tag), busy, 0);
    checkOutput($sformatf("%s diff hold", tag), diff, expDiff);
  endtask

  initial begin
    // Reset asserted between clock edges must clear outputs immediately.
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset diff", diff, 0);
    checkOutput("reset bout", bout, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic operand pairs.
    runOp("9-3", 4'h9, 4'h3, 4'h6, 1'b0);
    runOp("3-9", 4'h3, 4'h9, 4'hA, 1'b1);
    runOp("0-1", 4'h0, 4'h1, 4'hF, 1'b1);
    runOp("F-F", 4'hF, 4'hF, 4'h0, 1'b0);

    // A second request during SHIFT is dropped, not queued.
    donePulses = 0;
    applyStimulus(4'h9, 4'h3);
    @(posedge clk);
    #1;
    donePulses += done;
    start = 1'b1;
    a     = 4'h1;
    b     = 4'h1;
    @(posedge clk);
    #1;
    donePulses += done;
    start = 1'b0;
    for (int e = 3; e <= 6; e++) begin
      @(posedge clk);
      #1;
      donePulses += done;
      if (e == 4) begin
        checkOutput("ignore diff", diff, 4'h6);
        checkOutput("ignore bout", bout, 0);
      end
    end
    checkOutput("ignore done count", donePulses, 1);
    checkOutput("ignore busy@E6", busy, 0);

    // Start held high: accepts at E0 and E6, done at E4 and E10.
    @(negedge clk);
    start = 1'b1;
    a     = 4'h5;
    b     = 4'h2;
    @(posedge clk);
    #1;
    checkOutput("held busy@E0", busy, 1);
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("held done@E%0d", k), done,
                  (k == 4 || k == 10) ? 1 : 0);
      checkOutput($sformatf("held busy@E%0d", k), busy,
                  (k == 5 || k == 11) ? 0 : 1);
      if (k == 4 || k == 10) begin
        checkOutput($sformatf("held diff@E%0d", k), diff, 4'h3);
      end
    end
    start = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("held busy@E12", busy, 0);

    // Reset two edges into an op: immediate clear, no done pulse afterwards.
    applyStimulus(4'h9, 4'h3);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checkOutput("abort busy@E2", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort busy", busy, 0);
    checkOutput("abort done", done, 0);
    checkOutput("abort diff", diff, 0);
    checkOutput("abort bout", bout, 0);
    donePulses = 0;
    for (int e = 0; e < 4; e++) begin
      @(posedge clk);
      #1;
      donePulses += done;
    end
    checkOutput("abort no done", donePulses, 0);
    @(negedge clk);
    rst_n = 1'b1;
    runOp("7-8", 4'h7, 4'h8, 4'hF, 1'b1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
